// File: rtl/key_pulse_gen_pkg.sv
// key_pkg: shared types and constants for the key_pulse_gen button conditioner.
// Holds the FSM state encoding, counter width and channel index map.
package key_pkg;

  localparam int CNT_W = 16;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_RAND  = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } key_state_t;

  // Terminal count for a window of n cycles, counted 0-based.
  function automatic logic [CNT_W-1:0] last_cnt(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/key_pulse_gen_if.sv
// key_pulse_gen_if: raw button inputs and conditioned pulse/level outputs.
// master = button/board side and consumer, slave = key_pulse_gen.
interface key_pulse_gen_if #(
  parameter int N_KEYS = 5
);

  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_pulse;
  logic [N_KEYS-1:0] key_level;
  logic              any_pulse;

  modport master (
    output key_raw,
    input  key_pulse,
    input  key_level,
    input  any_pulse
  );

  modport slave (
    input  key_raw,
    output key_pulse,
    output key_level,
    output any_pulse
  );

endinterface

// File: rtl/key_pulse_gen_channel.sv
// key_channel: 2-flop synchroniser, debounce FSM and press pulse for one button.
// Auto-repeat while held is built only when KEY_PULSE_AUTOREPEAT_EN is defined.
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20
`ifdef KEY_PULSE_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 150
`endif
) (
  input  logic clk_d,
  input  logic rst,
  input  logic i_raw,
  output logic o_pulse,
  output logic o_level,
  output logic o_pulse_nxt
);

  localparam logic [CNT_W-1:0] LAST = last_cnt(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam bit ONE_CYC = (DEBOUNCE_CYC == 1);

  logic [1:0]       r_sync;
  key_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;

  logic w_sync;
  logic w_accept;
  logic w_repeat;

  assign w_sync = r_sync[1];

  // With a 1-cycle window the first sync=1 sample already qualifies.
  assign w_accept = w_sync &&
                    ((r_state == IDLE && ONE_CYC) ||
                     (r_state == PRESS_CHK && r_cnt == LAST));

  assign o_pulse_nxt = w_accept | w_repeat;

  always_ff @(posedge clk_d) begin
    if (rst) begin
      r_sync  <= 2'b00;
      r_state <= IDLE;
      r_cnt   <= '0;
      o_pulse <= 1'b0;
      o_level <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_raw};
      o_pulse <= o_pulse_nxt;
      unique case (r_state)
        IDLE: begin
          if (w_sync) begin
            if (ONE_CYC) begin
              r_state <= HELD;
              o_level <= 1'b1;
            end else begin
              r_state <= PRESS_CHK;
              r_cnt   <= ONE;
            end
          end
        end
        PRESS_CHK: begin
          if (!w_sync) begin
            r_state <= IDLE;
          end else if (r_cnt == LAST) begin
            r_state <= HELD;
            o_level <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!w_sync) begin
            if (ONE_CYC) begin
              r_state <= IDLE;
              o_level <= 1'b0;
            end else begin
              r_state <= REL_CHK;
              r_cnt   <= ONE;
            end
          end
        end
        REL_CHK: begin
          if (w_sync) begin
            r_state <= HELD;
          end else if (r_cnt == LAST) begin
            r_state <= IDLE;
            o_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef KEY_PULSE_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_FIRST = last_cnt(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] REP_NEXT  = last_cnt(REPEAT_PERIOD);

  logic [CNT_W-1:0] r_rcnt;
  logic             r_rep;

  assign w_repeat = (r_state == HELD) && w_sync &&
                    (r_rcnt == (r_rep ? REP_NEXT : REP_FIRST));

  // Any exit from HELD, including a release bounce, restarts the delay.
  always_ff @(posedge clk_d) begin
    if (rst || r_state != HELD) begin
      r_rcnt <= '0;
      r_rep  <= 1'b0;
    end else if (w_repeat) begin
      r_rcnt <= '0;
      r_rep  <= 1'b1;
    end else begin
      r_rcnt <= r_rcnt + 1'b1;
    end
  end
`else
  assign w_repeat = 1'b0;
`endif

endmodule

// File: rtl/key_pulse_gen.sv
// key_pulse_gen: N_KEYS debounced button channels with one pulse per press.
// Define KEY_PULSE_AUTOREPEAT_EN to add auto-repeat pulses while a key is held.
module key_pulse_gen
  import key_pkg::*;
#(
  parameter int N_KEYS        = 5,
  parameter int DEBOUNCE_CYC  = 20,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 150
) (
  input logic           clk_d,
  input logic           rst,
  key_pulse_gen_if.slave bus
);

  localparam bit CFG_OK = (DEBOUNCE_CYC >= 1) &&
                          (DEBOUNCE_CYC <= 65535) &&
                          (REPEAT_DELAY >= 1) &&
                          (REPEAT_PERIOD >= 1) &&
                          (N_KEYS > KEY_RAND);

  if (!CFG_OK) begin : g_bad_cfg
    $error("key_pulse_gen: illegal parameter set");
  end

  logic [N_KEYS-1:0] w_pulse;
  logic [N_KEYS-1:0] w_level;
  logic [N_KEYS-1:0] w_pulse_nxt;
  logic              r_any;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
`ifdef KEY_PULSE_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk_d      (clk_d),
      .rst        (rst),
      .i_raw      (bus.key_raw[g]),
      .o_pulse    (w_pulse[g]),
      .o_level    (w_level[g]),
      .o_pulse_nxt(w_pulse_nxt[g])
    );
  end

  // OR the next-state pulses so any_pulse lines up with key_pulse.
  always_ff @(posedge clk_d) begin
    if (rst) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |w_pulse_nxt;
    end
  end

  assign bus.key_pulse = w_pulse;
  assign bus.key_level = w_level;
  assign bus.any_pulse = r_any;

endmodule

// File: tb/tb_key_pulse_gen.sv
// tb_key_pulse_gen: directed table and sequence checks for key_pulse_gen.
// Cycle c counts rising edges after the raw change; outputs read 1 time unit past each edge.
module tb_key_pulse_gen;
  import key_pkg::*;

  localparam int NK = 5;
  localparam int DB = 20;

  logic clk_d = 1'b0;
  logic rst;

  key_pulse_gen_if #(.N_KEYS(NK)) bus();

  key_pulse_gen #(
    .N_KEYS       (NK),
    .DEBOUNCE_CYC (DB),
    .REPEAT_DELAY (50),
    .REPEAT_PERIOD(10)
  ) dut (
    .clk_d(clk_d),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk_d = ~clk_d;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NK-1:0] mask;
    int            hi_len;
    int            exp_cnt;
    int            exp_off;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_d);
    #1;
  endtask

  task automatic idle(input int n);
    bus.key_raw = '0;
    repeat (n) step();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int npulse, first, lvl_first, any_bad;
    logic [NK-1:0] pat;
    npulse = 0; first = -1; lvl_first = -1; any_bad = 0; pat = '0;
    bus.key_raw = v.mask;
    for (int c = 1; c <= v.hi_len + 60; c++) begin
      step();
      if (bus.any_pulse !== (|bus.key_pulse)) any_bad++;
      if (bus.key_pulse != '0) begin
        npulse++;
        if (first < 0) begin
          first = c;
          pat = bus.key_pulse;
        end
      end
      if (bus.key_level != '0 && lvl_first < 0) lvl_first = c;
      if (c == v.hi_len) bus.key_raw = '0;
    end
    chk($sformatf("v%0d_count", idx), npulse, v.exp_cnt);
    chk($sformatf("v%0d_pulse_cyc", idx), first, v.exp_off);
    chk($sformatf("v%0d_pulse_bits", idx), 32'(pat),
        v.exp_cnt > 0 ? 32'(v.mask) : 32'd0);
    chk($sformatf("v%0d_level_rise", idx), lvl_first, v.exp_off);
    chk($sformatf("v%0d_level_end", idx), 32'(bus.key_level), 32'd0);
    chk($sformatf("v%0d_any_pulse", idx), any_bad, 0);
  endtask

  initial begin
    int np, first, lvl100;
    int pc[$];

    vt[0] = '{5'b00001, 100, 1, 22};
    vt[1] = '{5'b10000, 19, 0, -1};
    vt[2] = '{5'b10000, 20, 1, 22};
    vt[3] = '{5'b01010, 60, 1, 22};
    vt[4] = '{5'b00100, 1, 0, -1};
    vt[5] = '{5'b11111, 30, 1, 22};

    rst = 1'b1;
    bus.key_raw = '0;
    repeat (3) step();
    chk("reset_pulse", 32'(bus.key_pulse), 0);
    chk("reset_level", 32'(bus.key_level), 0);
    chk("reset_any", 32'(bus.any_pulse), 0);
    rst = 1'b0;
    idle(5);

    for (int i = 0; i < 6; i++) begin
      run_vec(vt[i], i);
      idle(10);
    end

    // Press bounce, clean hold, then release bounce on KEY_LEFT.
    np = 0; first = -1; lvl100 = 0;
    bus.key_raw = '0;
    bus.key_raw[KEY_LEFT] = 1'b1;
    for (int c = 1; c <= 160; c++) begin
      step();
      if (bus.key_pulse[KEY_LEFT]) begin
        np++;
        if (first < 0) first = c;
      end
      if (c == 100) lvl100 = int'(bus.key_level[KEY_LEFT]);
      if (c < 30) bus.key_raw[KEY_LEFT] = ((c / 3) % 2) == 0;
      else if (c < 80) bus.key_raw[KEY_LEFT] = 1'b1;
      else if (c < 110) bus.key_raw[KEY_LEFT] = (((c - 80) / 3) % 2) == 1;
      else bus.key_raw[KEY_LEFT] = 1'b0;
    end
    chk("bounce_count", np, 1);
    chk("bounce_pulse_cyc", first, 52);
    chk("bounce_level_rel", lvl100, 1);
    chk("bounce_level_end", 32'(bus.key_level), 0);
    idle(10);

    // Reset while key 0 is held: full re-debounce afterwards.
    pc.delete();
    bus.key_raw = 5'b00001;
    for (int c = 1; c <= 80; c++) begin
      step();
      if (bus.key_pulse[KEY_UP]) pc.push_back(c);
      if (c == 31) begin
        chk("rst_hold_pulse", 32'(bus.key_pulse), 0);
        chk("rst_hold_level", 32'(bus.key_level), 0);
        rst = 1'b0;
      end
      if (c == 30) rst = 1'b1;
    end
    chk("rst_hold_count", pc.size(), 2);
    chk("rst_hold_first", pc.size() > 0 ? pc[0] : -1, 22);
    chk("rst_hold_second", pc.size() > 1 ? pc[1] : -1, 53);
    chk("rst_hold_level_on", 32'(bus.key_level), 32'd1);
    idle(40);

`ifdef KEY_PULSE_AUTOREPEAT_EN
    pc.delete();
    bus.key_raw = 5'b00001;
    for (int c = 1; c <= 200; c++) begin
      step();
      if (bus.key_pulse[KEY_UP]) pc.push_back(c);
      if (c == 122) bus.key_raw = '0;
    end
    chk("rep_count", pc.size(), 7);
    chk("rep_first", pc.size() > 0 ? pc[0] : -1, 22);
    for (int k = 1; k < 7; k++) begin
      chk($sformatf("rep_%0d", k), pc.size() > k ? pc[k] : -1,
          62 + 10 * k);
    end
`else
    np = 0;
    bus.key_raw = 5'b01000;
    for (int c = 1; c <= 340; c++) begin
      step();
      if (bus.key_pulse[KEY_RIGHT]) np++;
      if (c == 300) bus.key_raw = '0;
    end
    chk("long_hold_count", np, 1);
    chk("long_hold_level_end", 32'(bus.key_level), 0);
`endif
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
